// File: rtl/wave_rom_sequencer.sv
// DDS phase accumulator sequencing the waveform ROM into the DAC.
// Frequency changes land on period wraps; stop completes at a period boundary.
module wave_rom_sequencer #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] IDLE_CODE = 8'd128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic                   freq_load,
    input  logic [7:0]             amp,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_data,
    output logic [DATA_WIDTH-1:0]  da_data,
    output logic                   da_valid,
    output logic                   busy,
    output logic                   period_done
);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING, DRAIN} state_t;

    localparam int CW = $clog2(ROM_LATENCY + 2);

    state_t                   state;
    logic [PHASE_WIDTH-1:0]   phase;
    logic [PHASE_WIDTH-1:0]   inc_active;
    logic [PHASE_WIDTH-1:0]   inc_pending;
    logic                     pend_flag;
    logic                     rom_req;
    logic [ROM_LATENCY-1:0]   req_pipe;
    logic [CW-1:0]            drain_cnt;

    logic [PHASE_WIDTH:0]     sum;
    logic                     accum;
    logic                     wrap;
    logic                     apply;
    logic [8:0]               gain;
    logic [DATA_WIDTH+7:0]    prod;
    logic [DATA_WIDTH-1:0]    scaled;

    always_comb begin
        sum    = {1'b0, phase} + {1'b0, inc_active};
        accum  = (state == RUN) || (state == STOPPING);
        wrap   = accum && sum[PHASE_WIDTH];
        apply  = pend_flag && ((state == IDLE) || wrap);
        gain   = {1'b0, amp} + 9'd1;
        prod   = {8'b0, rom_data} * {{(DATA_WIDTH-1){1'b0}}, gain};
        scaled = DATA_WIDTH'(prod >> 8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            inc_active  <= '0;
            inc_pending <= '0;
            pend_flag   <= 1'b0;
            rom_req     <= 1'b0;
            req_pipe    <= '0;
            drain_cnt   <= '0;
            rom_addr    <= '0;
            da_data     <= IDLE_CODE;
            da_valid    <= 1'b0;
            busy        <= 1'b0;
            period_done <= 1'b0;
        end else begin
            // A load coinciding with an apply stays pending for the next wrap.
            if (freq_load) inc_pending <= freq_word;
            if (apply) inc_active <= inc_pending;
            pend_flag   <= freq_load | (pend_flag & ~apply);
            period_done <= wrap;

            req_pipe[0] <= rom_req;
            for (int i = 1; i < ROM_LATENCY; i++)
                req_pipe[i] <= req_pipe[i-1];
            da_valid <= req_pipe[ROM_LATENCY-1];
            da_data  <= req_pipe[ROM_LATENCY-1] ? scaled : IDLE_CODE;

            unique case (state)
                IDLE: begin
                    phase    <= '0;
                    rom_addr <= '0;
                    if (en && (inc_active != '0)) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        rom_req <= 1'b1;
                    end
                end
                RUN: begin
                    phase    <= sum[PHASE_WIDTH-1:0];
                    rom_addr <= sum[PHASE_WIDTH-1 -: ADDR_WIDTH];
                    if (!en) state <= STOPPING;
                end
                STOPPING: begin
                    if (en) begin
                        state    <= RUN;
                        phase    <= sum[PHASE_WIDTH-1:0];
                        rom_addr <= sum[PHASE_WIDTH-1 -: ADDR_WIDTH];
                    end else if (sum[PHASE_WIDTH]) begin
                        state     <= DRAIN;
                        phase     <= '0;
                        rom_addr  <= '0;
                        rom_req   <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        phase    <= sum[PHASE_WIDTH-1:0];
                        rom_addr <= sum[PHASE_WIDTH-1 -: ADDR_WIDTH];
                    end
                end
                DRAIN: begin
                    // Hold busy until the last requested sample has left the scaler.
                    if (drain_cnt == CW'(ROM_LATENCY)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
